// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the FSM state encoding and the fixed field widths of len/rep.
package seq_pattern_pkg;

    localparam int LEN_W     = 4;
    localparam int REP_W     = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serialises pattern[len_eff-1:0] MSB-first, rep+1 times back-to-back, then pulses done.
// Latency: first bit one cycle after start is accepted; no backpressure, start ignored while busy.
// Abort cancels SHIFT at the next edge with no done pulse.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] rep,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] pat_al;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] len_m1;
    logic [REP_W-1:0] rep_cnt;
    logic             accept;
    logic             last_bit;
    int               len_eff;

    // The pattern is left-aligned so the first bit to send always sits at the MSB.
    always_comb begin
        len_eff = ((len == '0) || (int'(len) > WIDTH)) ? WIDTH : int'(len);
        pat_al  = pattern << (WIDTH - len_eff);
    end

    assign accept   = (state == IDLE) && start && !abort;
    assign last_bit = (bit_cnt == '0) && (rep_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = SHIFT;
            SHIFT:   if (abort) nxt = IDLE;
                     else if (last_bit) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        out   = 1'b0;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            SHIFT: begin
                out   = sh_q[WIDTH-1];
                valid = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // pat_q keeps the aligned pattern so each repetition reloads the shifter without a gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= '0;
            sh_q    <= '0;
            bit_cnt <= '0;
            len_m1  <= '0;
            rep_cnt <= '0;
        end else if (accept) begin
            pat_q   <= pat_al;
            sh_q    <= pat_al;
            bit_cnt <= CNT_W'(len_eff - 1);
            len_m1  <= CNT_W'(len_eff - 1);
            rep_cnt <= rep;
        end else if ((state == SHIFT) && !abort) begin
            if (bit_cnt == '0) begin
                if (rep_cnt != '0) begin
                    rep_cnt <= rep_cnt - 1'b1;
                    bit_cnt <= len_m1;
                    sh_q    <= pat_q;
                end
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
                sh_q    <= {sh_q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomised and directed checks of seq_pattern_tx against a bit-list reference model.
module tb_seq_pattern_tx;

    localparam int W    = 8;
    localparam int MAXC = 300;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] pattern;
    logic [3:0]   len;
    logic [3:0]   rep;
    logic         out;
    logic         valid;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // Per-cycle samples packed as {valid, out, done, busy}.
    logic [3:0] obs  [MAXC];
    logic [3:0] expv [MAXC];
    int         exp_len;

    seq_pattern_tx #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .rep     (rep),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference: list of bits to send, then a timeline of expected outputs.
    function automatic int build_exp(input logic [W-1:0] p, input int l, input int r, input int ab);
        bit q[$];
        int le;
        int n;
        le = (l == 0 || l > W) ? W : l;
        for (int rr = 0; rr <= r; rr++)
            for (int i = le - 1; i >= 0; i--)
                q.push_back(p[i]);
        n = q.size();
        exp_len = n;
        for (int k = 0; k < MAXC; k++) begin
            if (ab >= 0 && ab < n)
                expv[k] = (k <= ab) ? {1'b1, q[k], 1'b0, 1'b1} : 4'b0000;
            else if (k < n)
                expv[k] = {1'b1, q[k], 1'b0, 1'b1};
            else if (k == n)
                expv[k] = 4'b0011;
            else
                expv[k] = 4'b0000;
        end
        return (ab >= 0 && ab < n) ? ab + 4 : n + 3;
    endfunction

    task automatic launch(input logic [W-1:0] p, input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        pattern = p;
        len     = l;
        rep     = r;
        start   = 1'b1;
        abort   = 1'b0;
    endtask

    // Samples n cycles after the accepting edge; optional mid-stream start/abort and input churn.
    task automatic record(input int n, input int start_at, input int abort_at, input bit scramble);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs[k] = {valid, out, done, busy};
            start  = (k == start_at);
            abort  = (k == abort_at);
            if (scramble) begin
                pattern = W'($urandom);
                len     = 4'($urandom);
                rep     = 4'($urandom);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({valid, out, done, busy} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got vodb=%b exp=0000", k, {valid, out, done, busy});
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({valid, out, done, busy} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got vodb=%b exp=0000", k, {valid, out, done, busy});
            end
        end
    endtask

    task automatic test_overlap();
        int n;
        int det;
        logic [3:0] sh4;
        launch(8'h0A, 4'd4, 4'd1);
        n = build_exp(8'h0A, 4, 1, -1);
        record(n, -1, -1, 1'b0);
        det = 0;
        sh4 = 4'b0000;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                failures++;
                $display("FAIL overlap cyc=%0d got vodb=%b exp=%b", k, obs[k], expv[k]);
            end
            if (obs[k][3]) begin
                sh4 = {sh4[2:0], obs[k][2]};
                if (sh4 == 4'b1010) det++;
            end
        end
        checks++;
        if (det !== 3) begin
            failures++;
            $display("FAIL overlap_detect got=%0d exp=3", det);
        end
    endtask

    task automatic test_len_sat();
        int n;
        logic [7:0] got;
        for (int t = 0; t < 2; t++) begin
            launch(8'hA5, (t == 0) ? 4'd0 : 4'd12, 4'd0);
            n = build_exp(8'hA5, (t == 0) ? 0 : 12, 0, -1);
            record(n, -1, -1, 1'b0);
            got = '0;
            for (int k = 0; k < n; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    failures++;
                    $display("FAIL len_sat%0d cyc=%0d got vodb=%b exp=%b", t, k, obs[k], expv[k]);
                end
                if (k < 8) got = {got[6:0], obs[k][2]};
            end
            checks++;
            if (got !== 8'hA5) begin
                failures++;
                $display("FAIL len_sat%0d_stream got=%h exp=a5", t, got);
            end
        end
    endtask

    task automatic test_busy_abort();
        int n;
        launch(8'hF0, 4'd8, 4'd0);
        n = build_exp(8'hF0, 8, 0, -1);
        record(n, 2, -1, 1'b1);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                failures++;
                $display("FAIL busy_restart cyc=%0d got vodb=%b exp=%b", k, obs[k], expv[k]);
            end
        end
        launch(8'hF0, 4'd8, 4'd0);
        n = build_exp(8'hF0, 8, 0, 3);
        record(n, -1, 3, 1'b0);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                failures++;
                $display("FAIL abort cyc=%0d got vodb=%b exp=%b", k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        launch(8'hF0, 4'd8, 4'd3);
        record(4, -1, -1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({valid, out, done, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_immediate got vodb=%b exp=0000", {valid, out, done, busy});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        record(5, -1, -1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs[k] !== 4'b0000) begin
                failures++;
                $display("FAIL async_reset_no_done cyc=%0d got vodb=%b exp=0000", k, obs[k]);
            end
        end
        launch(8'h01, 4'd1, 4'd15);
        n = build_exp(8'h01, 1, 15, -1);
        record(n, -1, -1, 1'b0);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                failures++;
                $display("FAIL post_reset_tx cyc=%0d got vodb=%b exp=%b", k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        pattern = 8'hFF;
        len     = 4'd8;
        rep     = 4'd0;
        start   = 1'b1;
        abort   = 1'b1;
        record(4, -1, -1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs[k] !== 4'b0000) begin
                failures++;
                $display("FAIL start_abort cyc=%0d got vodb=%b exp=0000", k, obs[k]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int ab;
        int sa;
        int stop;
        logic [W-1:0] p;
        int l;
        int r;
        for (int it = 0; it < 25; it++) begin
            p  = W'($urandom);
            l  = $urandom_range(0, 15);
            r  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
            launch(p, 4'(l), 4'(r));
            n = build_exp(p, l, r, ab);
            stop = (ab >= 0 && ab < exp_len) ? ab : exp_len;
            sa = $urandom_range(0, stop);
            record(n, sa, ab, 1'b1);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    failures++;
                    $display("FAIL random it=%0d p=%h l=%0d r=%0d ab=%0d cyc=%0d got vodb=%b exp=%b",
                             it, p, l, r, ab, k, obs[k], expv[k]);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        rep     = '0;
        test_reset();
        test_overlap();
        test_len_sat();
        test_busy_abort();
        test_async_reset();
        test_start_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
